// File: rtl/i_cache_loader_if.sv
// Loader stream (valid/ready word input) and i-cache byte write port, bundled for i_cache_loader.
// slave = controller side, master = loader/memory environment side.
interface i_cache_loader_if #(
    parameter int Depth     = 120,
    parameter int ElemWidth = 8,
    parameter int DPW       = 32
);
    localparam int AddrW = $clog2(Depth);

    logic                 ld_valid_i;
    logic [DPW-1:0]       ld_data_i;
    logic                 ld_ready_o;
    logic                 mem_we_o;
    logic [AddrW-1:0]     mem_waddr_o;
    logic [ElemWidth-1:0] mem_wdata_o;

    modport slave (
        input  ld_valid_i, ld_data_i,
        output ld_ready_o, mem_we_o, mem_waddr_o, mem_wdata_o
    );

    modport master (
        output ld_valid_i, ld_data_i,
        input  ld_ready_o, mem_we_o, mem_waddr_o, mem_wdata_o
    );
endinterface

// File: rtl/i_cache_loader.sv
// Sequential i-cache loader: takes 32-bit words, writes them as little-endian bytes, stalls fetch until done.
// Optional image checksum verification is enabled by defining I_CACHE_LOADER_CSUM_EN.
module i_cache_loader #(
    parameter int ElemWidth = 8,
    parameter int Depth     = 120,
    parameter int DPW       = 32,
    localparam int AddrW    = $clog2(Depth),
    localparam int LenW     = $clog2(Depth / 4 + 1)
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               load_start_i,
    input  logic [LenW-1:0]    load_len_i,
    input  logic [DPW-1:0]     ld_csum_i,
    i_cache_loader_if.slave    bus,
    output logic               core_stall_o,
    output logic               load_done_o,
    output logic               load_err_o,
    output logic               csum_err_o
);
    localparam int MaxWords = Depth / 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [AddrW-1:0]  r_addr;
    logic [1:0]        r_byte_cnt;
    logic [LenW-1:0]   r_words_left;
    logic [DPW-1:0]    r_word;
    logic              r_load_err;
    logic              r_we;
    logic              r_stall;
    logic              r_done;
    logic              w_we_nxt;
    logic              w_stall_nxt;
    logic              w_done_nxt;
    logic              w_len_ok;
    logic              w_start;
    logic              w_hs;
    logic              w_last_byte;
    logic              w_last_word;
    logic              w_csum_ok;

    assign w_len_ok    = (load_len_i != {LenW{1'b0}}) && (load_len_i <= LenW'(MaxWords));
    assign w_start     = load_start_i && ((r_state == S_IDLE) || (r_state == S_RUN));
    assign w_hs        = (r_state == S_ACCEPT) && bus.ld_valid_i;
    assign w_last_byte = (r_state == S_WRITE) && (r_byte_cnt == 2'd3);
    assign w_last_word = (r_words_left == LenW'(1));

`ifdef I_CACHE_LOADER_CSUM_EN
    logic [DPW-1:0] r_acc;
    logic [DPW-1:0] r_csum;
    logic           r_csum_err;

    assign w_csum_ok  = (r_acc == r_csum);
    assign csum_err_o = r_csum_err;

    // Checksum accumulator, expected value latch and sticky mismatch flag
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_acc      <= {DPW{1'b0}};
            r_csum     <= {DPW{1'b0}};
            r_csum_err <= 1'b0;
        end else if (w_start) begin
            r_acc      <= {DPW{1'b0}};
            r_csum     <= ld_csum_i;
            r_csum_err <= 1'b0;
        end else if (w_hs) begin
            r_acc      <= r_acc + bus.ld_data_i;
        end else if (w_last_byte && w_last_word && !w_csum_ok) begin
            r_csum_err <= 1'b1;
        end else begin
            r_acc      <= r_acc;
        end
    end
`else
    logic w_unused_csum;

    assign w_unused_csum = ^ld_csum_i;
    assign w_csum_ok     = 1'b1;
    assign csum_err_o    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (load_start_i && w_len_ok) w_next = S_ACCEPT;
                else                          w_next = S_IDLE;
            end
            S_ACCEPT: begin
                if (bus.ld_valid_i) w_next = S_WRITE;
                else                w_next = S_ACCEPT;
            end
            S_WRITE: begin
                if (!w_last_byte)     w_next = S_WRITE;
                else if (!w_last_word) w_next = S_ACCEPT;
                else if (w_csum_ok)   w_next = S_RUN;
                else                  w_next = S_IDLE;
            end
            S_RUN: begin
                if (!load_start_i)  w_next = S_RUN;
                else if (w_len_ok)  w_next = S_ACCEPT;
                else                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode, evaluated on the next state so the outputs can be registered
    always_comb begin
        w_we_nxt    = 1'b0;
        w_stall_nxt = 1'b1;
        w_done_nxt  = 1'b0;
        case (w_next)
            S_WRITE: w_we_nxt    = 1'b1;
            S_RUN: begin
                w_stall_nxt = 1'b0;
                w_done_nxt  = (r_state == S_WRITE);
            end
            default: begin
                w_we_nxt    = 1'b0;
                w_stall_nxt = 1'b1;
            end
        endcase
    end

    // Registered control outputs
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_we    <= 1'b0;
            r_stall <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_we    <= w_we_nxt;
            r_stall <= w_stall_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Datapath: the word register shifts right a byte per write so byte 0 of the word is always on the bus
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_addr       <= {AddrW{1'b0}};
            r_byte_cnt   <= 2'd0;
            r_words_left <= {LenW{1'b0}};
            r_word       <= {DPW{1'b0}};
            r_load_err   <= 1'b0;
        end else if (w_start) begin
            r_addr       <= {AddrW{1'b0}};
            r_byte_cnt   <= 2'd0;
            r_words_left <= load_len_i;
            r_load_err   <= !w_len_ok;
        end else if (w_hs) begin
            r_word       <= bus.ld_data_i;
            r_byte_cnt   <= 2'd0;
        end else if (r_state == S_WRITE) begin
            r_word       <= {{ElemWidth{1'b0}}, r_word[DPW-1:ElemWidth]};
            r_byte_cnt   <= r_byte_cnt + 2'd1;
            // hold the address on the image's final byte so it never points past the array
            if (!(w_last_byte && w_last_word)) r_addr <= r_addr + AddrW'(1);
            else                               r_addr <= r_addr;
            if (w_last_byte) r_words_left <= r_words_left - LenW'(1);
            else             r_words_left <= r_words_left;
        end else begin
            r_word       <= r_word;
        end
    end

    assign bus.ld_ready_o  = (r_state == S_ACCEPT);
    assign bus.mem_we_o    = r_we;
    assign bus.mem_waddr_o = r_addr;
    assign bus.mem_wdata_o = r_word[ElemWidth-1:0];
    assign core_stall_o    = r_stall;
    assign load_done_o     = r_done;
    assign load_err_o      = r_load_err;
endmodule

// File: tb/tb_i_cache_loader.sv
// Directed self-checking bench for i_cache_loader; logs every byte write and checks it against hand-derived bytes.
module tb_i_cache_loader;
    localparam int LenW = 5;

    logic            clk = 1'b0;
    logic            arst_n = 1'b0;
    logic            load_start_i = 1'b0;
    logic [LenW-1:0] load_len_i = 5'd0;
    logic [31:0]     ld_csum_i = 32'd0;
    logic            core_stall_o, load_done_o, load_err_o, csum_err_o;

    int total = 0;
    int bad   = 0;

    i_cache_loader_if bus ();

    i_cache_loader dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .load_start_i (load_start_i),
        .load_len_i   (load_len_i),
        .ld_csum_i    (ld_csum_i),
        .bus          (bus),
        .core_stall_o (core_stall_o),
        .load_done_o  (load_done_o),
        .load_err_o   (load_err_o),
        .csum_err_o   (csum_err_o)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         nwr = 0;
    int         ndone = 0;
    logic [6:0] log_addr [256];
    logic [7:0] log_data [256];
    int         log_cyc  [256];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mem_we_o && nwr < 256) begin
            log_addr[nwr] = bus.mem_waddr_o;
            log_data[nwr] = bus.mem_wdata_o;
            log_cyc[nwr]  = cyc;
            nwr = nwr + 1;
        end
        if (load_done_o) ndone = ndone + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, {31'd0, bus.ld_ready_o}, 32'd0);
        check({tag, "_we"},    {31'd0, bus.mem_we_o}, 32'd0);
        check({tag, "_waddr"}, {25'd0, bus.mem_waddr_o}, 32'd0);
        check({tag, "_wdata"}, {24'd0, bus.mem_wdata_o}, 32'd0);
        check({tag, "_stall"}, {31'd0, core_stall_o}, 32'd1);
        check({tag, "_done"},  {31'd0, load_done_o}, 32'd0);
        check({tag, "_lerr"},  {31'd0, load_err_o}, 32'd0);
        check({tag, "_cerr"},  {31'd0, csum_err_o}, 32'd0);
    endtask

    task automatic start_load(input logic [LenW-1:0] len, input logic [31:0] cs);
        @(negedge clk);
        load_start_i = 1'b1;
        load_len_i   = len;
        ld_csum_i    = cs;
        @(negedge clk);
        load_start_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input int gap, input string tag);
        int n;
        n = 0;
        bus.ld_valid_i = 1'b0;
        while (!bus.ld_ready_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, {31'd0, bus.ld_ready_o}, 32'd1);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check({tag, "_wait_ready"}, {31'd0, bus.ld_ready_o}, 32'd1);
            check({tag, "_wait_we"},    {31'd0, bus.mem_we_o}, 32'd0);
        end
        bus.ld_valid_i = 1'b1;
        bus.ld_data_i  = d;
        @(negedge clk);
        bus.ld_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!load_done_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"},  {31'd0, load_done_o}, 32'd1);
        check({tag, "_stall"}, {31'd0, core_stall_o}, 32'd0);
    endtask

    task automatic check_image(input int base, input int nwords, input logic [31:0] w0,
                               input logic [31:0] w1, input string tag);
        logic [31:0] w;
        check({tag, "_nwrites"}, nwr - base, 4 * nwords);
        for (int i = 0; i < 4 * nwords; i++) begin
            w = (i < 4) ? w0 : w1;
            check($sformatf("%s_addr%0d", tag, i), {25'd0, log_addr[base + i]}, i);
            check($sformatf("%s_byte%0d", tag, i), {24'd0, log_data[base + i]}, (w >> (8 * (i % 4))) & 32'hFF);
            if (i % 4 != 0)
                check($sformatf("%s_cyc%0d", tag, i), log_cyc[base + i], log_cyc[base + i - 1] + 1);
        end
    endtask

    int b;
    int d0;

    initial begin
        bus.ld_valid_i = 1'b0;
        bus.ld_data_i  = 32'd0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        arst_n = 1'b1;

        // basic two-word load
        b = nwr; d0 = ndone;
        start_load(5'd2, 32'd0);
        check("t1_stall_accept", {31'd0, core_stall_o}, 32'd1);
        send_word(32'h0050_0113, 0, "t1w0");
        send_word(32'h00C0_0193, 0, "t1w1");
        wait_done("t1");
        repeat (2) @(negedge clk);
        check("t1_ndone", ndone - d0, 32'd1);
        check_image(b, 2, 32'h0050_0113, 32'h00C0_0193, "t1");

        // restart from RUN with a 3-cycle valid gap between words
        b = nwr; d0 = ndone;
        start_load(5'd2, 32'd0);
        check("t2_stall_restart", {31'd0, core_stall_o}, 32'd1);
        send_word(32'h0050_0113, 0, "t2w0");
        send_word(32'h00C0_0193, 3, "t2w1");
        wait_done("t2");
        repeat (2) @(negedge clk);
        check("t2_ndone", ndone - d0, 32'd1);
        check_image(b, 2, 32'h0050_0113, 32'h00C0_0193, "t2");

        // length errors from IDLE
        @(negedge clk); arst_n = 1'b0;
        @(negedge clk); arst_n = 1'b1;
        start_load(5'd0, 32'd0);
        check("t3_len0_err",   {31'd0, load_err_o}, 32'd1);
        check("t3_len0_ready", {31'd0, bus.ld_ready_o}, 32'd0);
        check("t3_len0_stall", {31'd0, core_stall_o}, 32'd1);
        start_load(5'd31, 32'd0);
        check("t3_len31_err",   {31'd0, load_err_o}, 32'd1);
        check("t3_len31_ready", {31'd0, bus.ld_ready_o}, 32'd0);
        check("t3_len31_stall", {31'd0, core_stall_o}, 32'd1);
        start_load(5'd1, 32'd0);
        check("t3_len1_err",   {31'd0, load_err_o}, 32'd0);
        check("t3_len1_ready", {31'd0, bus.ld_ready_o}, 32'd1);
        b = nwr;
        send_word(32'hDEAD_BEEF, 0, "t3w0");
        wait_done("t3");
        check_image(b, 1, 32'hDEAD_BEEF, 32'd0, "t3");

        // asynchronous reset during byte 2 of the first word
        start_load(5'd2, 32'd0);
        send_word(32'h1122_3344, 0, "t4w0");
        @(negedge clk);
        @(negedge clk);
        check("t4_pre_we",    {31'd0, bus.mem_we_o}, 32'd1);
        check("t4_pre_waddr", {25'd0, bus.mem_waddr_o}, 32'd2);
        check("t4_pre_wdata", {24'd0, bus.mem_wdata_o}, 32'h22);
        #1 arst_n = 1'b0;
        #1 check_reset_vals("t4_rst");
        @(negedge clk);
        arst_n = 1'b1;
        b = nwr;
        start_load(5'd1, 32'd0);
        send_word(32'hA1B2_C3D4, 0, "t4w1");
        wait_done("t4");
        check_image(b, 1, 32'hA1B2_C3D4, 32'd0, "t4");

        // restart from RUN with len=1
        b = nwr;
        start_load(5'd1, 32'd0);
        check("t5_stall", {31'd0, core_stall_o}, 32'd1);
        send_word(32'h0000_0073, 0, "t5w0");
        wait_done("t5");
        check_image(b, 1, 32'h0000_0073, 32'd0, "t5");

`ifdef I_CACHE_LOADER_CSUM_EN
        b = nwr;
        start_load(5'd2, 32'h0110_02A6);
        send_word(32'h0050_0113, 0, "t6w0");
        send_word(32'h00C0_0193, 0, "t6w1");
        wait_done("t6");
        check("t6_cerr_ok", {31'd0, csum_err_o}, 32'd0);
        check_image(b, 2, 32'h0050_0113, 32'h00C0_0193, "t6");

        d0 = ndone;
        start_load(5'd2, 32'h0000_0000);
        send_word(32'h0050_0113, 0, "t7w0");
        send_word(32'h00C0_0193, 0, "t7w1");
        for (int n = 0; n < 30 && !csum_err_o; n++) @(negedge clk);
        check("t7_cerr", {31'd0, csum_err_o}, 32'd1);
        repeat (3) @(negedge clk);
        check("t7_ndone", ndone - d0, 32'd0);
        check("t7_stall", {31'd0, core_stall_o}, 32'd1);
        check("t7_ready", {31'd0, bus.ld_ready_o}, 32'd0);
        check("t7_we",    {31'd0, bus.mem_we_o}, 32'd0);
`else
        check("t6_cerr_tied", {31'd0, csum_err_o}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i_cache_loader.md
# i_cache_loader

Sequential load controller for the byte-wide instruction cache memory. It accepts 32-bit instruction words from a host loader over a valid/ready stream and writes them as little-endian bytes into the i-cache write port. It holds the core's fetch stage stalled until a complete program image has been written, then releases the core. It sits between the off-core program loader and the `i_cache` storage array, and drives `core_stall_o` into the fetch/PC stage.

## Interface
- `ElemWidth`, 8: width of one i-cache memory element (bits); fixed at 8.
- `Depth`, 120: i-cache depth in elements; maximum program = `Depth/4` words.
- `AddrW`, `$clog2(Depth)`: byte address width.
- `LenW`, `$clog2(Depth/4+1)`: word-count width.

- `clk` in 1: single clock; all state updates on the rising edge.
- `arst_n` in 1: reset, asynchronous and active-low.
- `load_start_i` in 1: single-cycle request to begin a load.
- `load_len_i` in LenW: number of words to load; sampled with `load_start_i`.
- `ld_csum_i` in DPW: expected checksum; sampled with `load_start_i` (used only with the macro).
- `ld_valid_i` in 1: loader word valid.
- `ld_data_i` in DPW: loader instruction word.
- `ld_ready_o` out 1: controller can accept a word.
- `mem_we_o` out 1: i-cache byte write enable.
- `mem_waddr_o` out AddrW: i-cache byte address.
- `mem_wdata_o` out ElemWidth: i-cache write byte.
- `core_stall_o` out 1: holds fetch/PC while asserted.
- `load_done_o` out 1: one-cycle pulse when the image is complete.
- `load_err_o` out 1: sticky length error.
- `csum_err_o` out 1: sticky checksum mismatch; constant 0 without the macro.

## Operation
- FSM states: IDLE, ACCEPT, WRITE, RUN. Reset enters IDLE.
- IDLE:
  - `core_stall_o=1`.
  - On `load_start_i`, clear `load_err_o`/`csum_err_o`, latch length and checksum, and clear the address, byte counter and checksum accumulator.
  - If `load_len_i==0` or `load_len_i>Depth/4`, set `load_err_o` and stay in IDLE. Otherwise go to ACCEPT.
- ACCEPT: `ld_ready_o=1`. When `ld_valid_i` is also high, latch `ld_data_i`, add it to the accumulator (32-bit wrapping sum), and go to WRITE with `byte_cnt=0`.
- WRITE:
  - `mem_we_o=1` for exactly 4 cycles.
  - `mem_wdata_o = word[8*byte_cnt+7 -: 8]`; `mem_waddr_o` increments by 1 each cycle.
  - After byte 3, `words_left` decrements. If `words_left` is not 0, go to ACCEPT. If it is 0, go to RUN and pulse `load_done_o`.
- RUN: `core_stall_o=0`. A `load_start_i` pulse restarts the load exactly as in IDLE, and `core_stall_o` rises the next cycle.
- `load_start_i` is ignored in ACCEPT and WRITE.
- `ld_ready_o` is low in every state except ACCEPT. `ld_valid_i` outside ACCEPT has no effect and the word is not consumed.
- `mem_waddr_o` never exceeds `Depth-1`; this is guaranteed by the length check.

## Timing
- Reset values: `ld_ready_o=0`, `mem_we_o=0`, `mem_waddr_o=0`, `mem_wdata_o=0`, `core_stall_o=1`, `load_done_o=0`, `load_err_o=0`, `csum_err_o=0`.
- Word throughput is 5 cycles: 1 cycle ACCEPT handshake plus 4 cycles WRITE. Any `ld_valid_i` gaps extend ACCEPT.
- The handshake in cycle N produces byte writes in cycles N+1 to N+4. The memory captures each byte at the end of its cycle.
- `load_done_o` is high in the first RUN cycle. `core_stall_o` is 0 in that same cycle.
- Asserting `arst_n` low mid-load immediately returns all outputs to reset values. Bytes already written stay in memory, and the core remains stalled until a new complete load.
- All outputs are driven from registered state; there are no combinational input-to-output paths except `ld_ready_o`, which is decoded from state.

## Configuration
- `I_CACHE_LOADER_CSUM_EN` defined:
  - After the final word's bytes are written, the accumulator is compared to the latched `ld_csum_i`.
  - On a match, go to RUN and pulse `load_done_o`.
  - On a mismatch, set `csum_err_o`, return to IDLE with the core still stalled, and do not pulse `load_done_o`.
- Not defined: no accumulator logic, `csum_err_o` tied 0, and `ld_csum_i` is unused.

## Test plan
- Start with len=2 and send 0x00500113 then 0x00C00193. Required: bytes 13,01,50,00,93,01,C0,00 written to addresses 0–7 on consecutive WRITE cycles, `load_done_o` pulses once, and `core_stall_o` drops in the same cycle.
- Same load with `ld_valid_i` low for 3 cycles between words. Required: identical memory contents, `ld_ready_o` held high while waiting, and no spurious `mem_we_o`.
- Start with len=0, then with len=31 (Depth=120). Required: `load_err_o=1` both times, no `ld_ready_o`, stall stays 1. A later valid len=1 start clears `load_err_o`.
- Assert `arst_n` low during byte 2 of word 1. Required: outputs return to reset values immediately. After release, a fresh len=1 load writes to addresses 0–3.
- From RUN, pulse `load_start_i` with len=1. Required: `core_stall_o=1` next cycle, and the new word is written at addresses 0–3.
- With the macro defined, load len=2 with `ld_csum_i`=0x0110_02A6 (the correct sum), then repeat with 0x0. Required: first `load_done_o` pulses; second `csum_err_o=1`, no done pulse, FSM in IDLE, stall held.
